msrv32_dbus_ctrl: RTL

Data-bus master that converts one load/store request from the execute stage into a single AHB-Lite transfer. It captures the read data and response and hands them to the load unit (msrv32_lu) as its data_in, ahb_resp_in, iadder_1_to_0_in, load_size_in and load_unsigned_in. One outstanding transfer at a time. Misaligned accesses are rejected without any bus activity.

---
 rtl/msrv32_pkg.sv | 23 ++
 rtl/msrv32_store_align.sv | 33 +++
 rtl/msrv32_dbus_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 data-bus path: access sizes, AHB transfer
// types and the bus-controller state enum.
package msrv32_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // Both 10 and 11 request a word, so the AHB size saturates at 010.
  function automatic logic [2:0] to_hsize(input logic [1:0] size);
    case (size)
      SIZE_BYTE: to_hsize = 3'b000;
      SIZE_HALF: to_hsize = 3'b001;
      default:   to_hsize = 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// Replicates right-aligned store data across byte lanes, builds the lane
// strobes and flags accesses that do not sit on their natural boundary.
module msrv32_store_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hwdata,
  output logic [3:0]  wr_mask,
  output logic        misaligned
);

  always_comb begin
    hwdata     = wdata;
    wr_mask    = 4'b1111;
    misaligned = |addr_lo;
    case (size)
      SIZE_BYTE: begin
        hwdata     = {4{wdata[7:0]}};
        wr_mask    = 4'b0001 << addr_lo;
        misaligned = 1'b0;
      end
      SIZE_HALF: begin
        hwdata     = {2{wdata[15:0]}};
        wr_mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_dbus_ctrl.sv
// Single-outstanding AHB-Lite data-bus master: turns one load/store request
// into one transfer and latches the result for the load unit.
module msrv32_dbus_ctrl
  import msrv32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  input  logic              req_write_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [31:0]       req_wdata_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic [1:0]        htrans_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [31:0]       hwdata_out,
  output logic [3:0]        wr_mask_out,
  input  logic [31:0]       hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in,
  output logic              done_out,
  output logic [31:0]       lu_data_out,
  output logic              lu_resp_out,
  output logic [1:0]        lu_addr_lo_out,
  output logic [1:0]        lu_size_out,
  output logic              lu_unsigned_out,
  output logic              misaligned_out
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("msrv32_dbus_ctrl supports only a 32-bit data bus");
  end

  state_t            state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       hwdata_q;
  logic [3:0]        mask_q;
  logic              done_q, mis_q;
  logic [31:0]       lu_data_q;
  logic              lu_resp_q;

  logic [31:0] align_data;
  logic [3:0]  align_mask;
  logic        align_mis;
  logic        accept, reject, complete;

  // Alignment is evaluated on the live request so a bad access never leaves IDLE.
  msrv32_store_align u_align (
    .size       (req_size_in),
    .addr_lo    (req_addr_in[1:0]),
    .wdata      (req_wdata_in),
    .hwdata     (align_data),
    .wr_mask    (align_mask),
    .misaligned (align_mis)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_out   = 1'b0;
    htrans_out  = HTRANS_IDLE;
    haddr_out   = '0;
    hwrite_out  = 1'b0;
    hsize_out   = 3'b000;
    hwdata_out  = '0;
    wr_mask_out = '0;
    accept      = 1'b0;
    reject      = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        accept    = req_valid_in;
        reject    = req_valid_in && align_mis;
        if (req_valid_in && !align_mis) state_d = ADDR;
      end
      ADDR: begin
        htrans_out = HTRANS_NONSEQ;
        haddr_out  = addr_q;
        hwrite_out = wr_q;
        hsize_out  = to_hsize(size_q);
        if (hready_in) state_d = DATA;
      end
      DATA: begin
        hwdata_out  = wr_q ? hwdata_q : '0;
        wr_mask_out = wr_q ? mask_q : '0;
        complete    = hready_in;
        if (hready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture at accept, response capture on the final data-phase cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      hwdata_q  <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      lu_data_q <= '0;
      lu_resp_q <= 1'b0;
    end else begin
      done_q <= complete || reject;
      mis_q  <= reject;
      if (accept) begin
        wr_q     <= req_write_in;
        addr_q   <= req_addr_in;
        size_q   <= req_size_in;
        uns_q    <= req_unsigned_in;
        hwdata_q <= align_data;
        mask_q   <= align_mask;
      end
      if (reject) lu_resp_q <= 1'b1;
      if (complete) begin
        lu_resp_q <= hresp_in;
        if (!wr_q) lu_data_q <= hrdata_in;
      end
    end
  end

  assign done_out        = done_q;
  assign misaligned_out  = mis_q;
  assign lu_data_out     = lu_data_q;
  assign lu_resp_out     = lu_resp_q;
  assign lu_addr_lo_out  = addr_q[1:0];
  assign lu_size_out     = size_q;
  assign lu_unsigned_out = uns_q;

endmodule
